// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: shared types and constants for the UART MMIO peripheral.
//   - uart_op_e   : op codes carried on the 2-bit uart_op strobe
//   - ST_*        : bit positions inside the STATUS read word
//   - tx_state_e  : serialiser FSM states
//   - rx_state_e  : deserialiser FSM states
//   - clamp_div   : applies the divisor floor to a programmed value
package uart_mmio_pkg;

  typedef enum logic [1:0] {
    OP_STATUS   = 2'd0,
    OP_TX_WRITE = 2'd1,
    OP_RX_POP   = 2'd2,
    OP_CONFIG   = 2'd3
  } uart_op_e;

  localparam int unsigned ST_RX_VALID     = 0;
  localparam int unsigned ST_TX_FULL      = 1;
  localparam int unsigned ST_TX_IDLE      = 2;
  localparam int unsigned ST_RX_OVERRUN   = 3;
  localparam int unsigned ST_FRAME_ERR    = 4;
  localparam int unsigned ST_TX_OVERFLOW  = 5;
  localparam int unsigned ST_RX_COUNT_LSB = 8;
  localparam int unsigned ST_TX_COUNT_LSB = 16;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxWaitHigh
  } rx_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] req, input logic [15:0] min_div);
    return (req < min_div) ? min_div : req;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_wdata (ignored when full unless i_pop frees a slot)
//   i_pop      : drop the head entry (ignored when empty)
//   o_rdata    : current head, combinational
//   o_full, o_empty, o_count : occupancy
module uart_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic [WIDTH-1:0]               i_wdata,
  output logic [WIDTH-1:0]               o_rdata,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // A simultaneous pop frees the head slot, so a push into a full FIFO is accepted.
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART responder with TX/RX FIFOs.
//   clk, rst_n    : core clock, asynchronous active-low reset
//   uart_op       : single-cycle op strobe (STATUS, TX_WRITE, RX_POP, CONFIG)
//   data_to_mem   : write data, valid with uart_op
//   uart_data_out : combinational read data for the current op
//   uart_rx       : asynchronous serial input
//   uart_tx       : serial output, idles high
//   rx_irq        : RX FIFO non-empty
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434,
  parameter logic [15:0] MIN_DIV     = 16'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  uart_op,
  input  logic [31:0] data_to_mem,
  output logic [31:0] uart_data_out,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        rx_irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  uart_op_e  w_op;
  logic      w_tx_write, w_rx_pop_op, w_cfg, w_clr;
  logic      w_unused_data;
  logic [15:0] r_div;
  logic      r_rx_overrun, r_frame_err, r_tx_overflow;

  // FIFO wiring
  logic          w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [7:0]    w_tx_head;
  logic [CW-1:0] w_tx_count;
  logic          w_rx_push, w_rx_full, w_rx_empty;
  logic [7:0]    w_rx_head;
  logic [CW-1:0] w_rx_count;

  // TX serialiser
  tx_state_e   r_tx_state, w_tx_state_d;
  logic [7:0]  r_tx_shift, w_tx_shift_d;
  logic [15:0] r_tx_div, w_tx_div_d, r_tx_cnt, w_tx_cnt_d;
  logic [2:0]  r_tx_idx, w_tx_idx_d;
  logic        w_tx_bit_end;

  // RX deserialiser
  rx_state_e   r_rx_state, w_rx_state_d;
  logic [7:0]  r_rx_shift, w_rx_shift_d;
  logic [15:0] r_rx_div, w_rx_div_d, r_rx_cnt, w_rx_cnt_d;
  logic [2:0]  r_rx_idx, w_rx_idx_d;
  logic [1:0]  r_sync;
  logic        r_rx_prev, w_rx_line, w_rx_fall, w_rx_bit_end, w_frame_evt;

  assign w_op          = uart_op_e'(uart_op);
  assign w_tx_write    = (w_op == OP_TX_WRITE);
  assign w_rx_pop_op   = (w_op == OP_RX_POP);
  assign w_cfg         = (w_op == OP_CONFIG);
  assign w_clr         = w_cfg && data_to_mem[16];
  assign w_unused_data = ^data_to_mem[31:17];

  // Full is judged before the serialiser's pop on the same edge.
  assign w_tx_push = w_tx_write && !w_tx_full;

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_wdata (data_to_mem[7:0]),
    .o_rdata (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop_op),
    .i_wdata (r_rx_shift),
    .o_rdata (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  assign rx_irq = !w_rx_empty;

  // ---------------- read mux ----------------
  always_comb begin
    uart_data_out = '0;
    case (w_op)
      OP_STATUS: begin
        uart_data_out[ST_RX_VALID]               = !w_rx_empty;
        uart_data_out[ST_TX_FULL]                = w_tx_full;
        uart_data_out[ST_TX_IDLE]                = (r_tx_state == TxIdle) && w_tx_empty;
        uart_data_out[ST_RX_OVERRUN]             = r_rx_overrun;
        uart_data_out[ST_FRAME_ERR]              = r_frame_err;
        uart_data_out[ST_TX_OVERFLOW]            = r_tx_overflow;
        uart_data_out[ST_RX_COUNT_LSB +: 8]      = 8'(w_rx_count);
        uart_data_out[ST_TX_COUNT_LSB +: 8]      = 8'(w_tx_count);
      end
      OP_RX_POP: if (!w_rx_empty) uart_data_out = {23'b0, 1'b1, w_rx_head};
      default: ;
    endcase
  end

  // ---------------- config + sticky flags ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div         <= DEFAULT_DIV;
      r_rx_overrun  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_tx_overflow <= 1'b0;
    end else begin
      if (w_cfg) r_div <= clamp_div(data_to_mem[15:0], MIN_DIV);
      // A new event on the clearing edge wins over the clear.
      r_rx_overrun  <= (r_rx_overrun && !w_clr) || (w_rx_push && w_rx_full && !w_rx_pop_op);
      r_frame_err   <= (r_frame_err && !w_clr) || w_frame_evt;
      r_tx_overflow <= (r_tx_overflow && !w_clr) || (w_tx_write && w_tx_full);
    end
  end

  // ---------------- TX FSM ----------------
  assign w_tx_bit_end = (r_tx_cnt == '0);

  always_comb begin
    w_tx_state_d = r_tx_state;
    w_tx_shift_d = r_tx_shift;
    w_tx_div_d   = r_tx_div;
    w_tx_cnt_d   = r_tx_cnt;
    w_tx_idx_d   = r_tx_idx;
    w_tx_pop     = 1'b0;
    unique case (r_tx_state)
      TxIdle: ;
      TxStart: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_d   = r_tx_div - 16'd1;
          w_tx_idx_d   = '0;
          w_tx_state_d = TxData;
        end else w_tx_cnt_d = r_tx_cnt - 16'd1;
      end
      TxData: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_d   = r_tx_div - 16'd1;
          w_tx_shift_d = r_tx_shift >> 1;
          w_tx_idx_d   = r_tx_idx + 3'd1;
          if (r_tx_idx == 3'd7) w_tx_state_d = TxStop;
        end else w_tx_cnt_d = r_tx_cnt - 16'd1;
      end
      TxStop: begin
        if (w_tx_bit_end) w_tx_state_d = TxIdle;
        else              w_tx_cnt_d   = r_tx_cnt - 16'd1;
      end
      default: w_tx_state_d = TxIdle;
    endcase
    // Load the next byte from IDLE, or straight out of a finished stop bit.
    if ((r_tx_state == TxIdle || (r_tx_state == TxStop && w_tx_bit_end)) && !w_tx_empty) begin
      w_tx_pop     = 1'b1;
      w_tx_shift_d = w_tx_head;
      w_tx_div_d   = r_div;
      w_tx_cnt_d   = r_div - 16'd1;
      w_tx_state_d = TxStart;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TxIdle;
      r_tx_shift <= '0;
      r_tx_div   <= DEFAULT_DIV;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
    end else begin
      r_tx_state <= w_tx_state_d;
      r_tx_shift <= w_tx_shift_d;
      r_tx_div   <= w_tx_div_d;
      r_tx_cnt   <= w_tx_cnt_d;
      r_tx_idx   <= w_tx_idx_d;
    end
  end

  // Decoded from reset-cleared state, so reset drives the line high immediately.
  assign uart_tx = (r_tx_state == TxStart) ? 1'b0 :
                   (r_tx_state == TxData)  ? r_tx_shift[0] : 1'b1;

  // ---------------- RX FSM ----------------
  assign w_rx_line    = r_sync[1];
  assign w_rx_fall    = r_rx_prev && !w_rx_line;
  assign w_rx_bit_end = (r_rx_cnt == '0);

  always_comb begin
    w_rx_state_d = r_rx_state;
    w_rx_shift_d = r_rx_shift;
    w_rx_div_d   = r_rx_div;
    w_rx_cnt_d   = r_rx_cnt;
    w_rx_idx_d   = r_rx_idx;
    w_rx_push    = 1'b0;
    w_frame_evt  = 1'b0;
    unique case (r_rx_state)
      RxIdle: begin
        if (w_rx_fall) begin
          w_rx_div_d   = r_div;
          w_rx_cnt_d   = (r_div >> 1) - 16'd1;
          w_rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (w_rx_bit_end) begin
          if (w_rx_line) w_rx_state_d = RxIdle;  // start bit vanished: glitch
          else begin
            w_rx_cnt_d   = r_rx_div - 16'd1;
            w_rx_idx_d   = '0;
            w_rx_state_d = RxData;
          end
        end else w_rx_cnt_d = r_rx_cnt - 16'd1;
      end
      RxData: begin
        if (w_rx_bit_end) begin
          w_rx_shift_d = {w_rx_line, r_rx_shift[7:1]};
          w_rx_cnt_d   = r_rx_div - 16'd1;
          w_rx_idx_d   = r_rx_idx + 3'd1;
          if (r_rx_idx == 3'd7) w_rx_state_d = RxStop;
        end else w_rx_cnt_d = r_rx_cnt - 16'd1;
      end
      RxStop: begin
        if (w_rx_bit_end) begin
          if (w_rx_line) begin
            w_rx_push    = 1'b1;
            w_rx_state_d = RxIdle;
          end else begin
            w_frame_evt  = 1'b1;
            w_rx_state_d = RxWaitHigh;
          end
        end else w_rx_cnt_d = r_rx_cnt - 16'd1;
      end
      RxWaitHigh: if (w_rx_line) w_rx_state_d = RxIdle;
      default: w_rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= 2'b11;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RxIdle;
      r_rx_shift <= '0;
      r_rx_div   <= DEFAULT_DIV;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
    end else begin
      r_sync     <= {r_sync[0], uart_rx};
      r_rx_prev  <= w_rx_line;
      r_rx_state <= w_rx_state_d;
      r_rx_shift <= w_rx_shift_d;
      r_rx_div   <= w_rx_div_d;
      r_rx_cnt   <= w_rx_cnt_d;
      r_rx_idx   <= w_rx_idx_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: self-checking bench for uart_mmio.
// Register-level vectors come from a table; TX bytes are scoreboarded against a line monitor,
// RX bytes against a model queue filled as frames are driven.
module tb_uart_mmio;
  import uart_mmio_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  uart_op = 2'd0;
  logic [31:0] data_to_mem = 32'd0;
  logic [31:0] uart_data_out;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        rx_irq;

  int n_checks = 0;
  int n_errors = 0;
  int tb_div = 4;
  bit mon_en = 1'b1;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [31:0] exp_out;
    logic        exp_tx;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[6];

  uart_mmio #(
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (16'd434),
    .MIN_DIV     (16'd4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_op       (uart_op),
    .data_to_mem   (data_to_mem),
    .uart_data_out (uart_data_out),
    .uart_rx       (uart_rx),
    .uart_tx       (uart_tx),
    .rx_irq        (rx_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; read data sampled mid-cycle, op committed on the next edge.
  task automatic do_op(input logic [1:0] op, input logic [31:0] d, output logic [31:0] rd);
    uart_op = op;
    data_to_mem = d;
    @(negedge clk);
    rd = uart_data_out;
    @(posedge clk);
    #1;
    uart_op = 2'd0;
    data_to_mem = 32'd0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int d);
    uart_rx = 1'b0;
    repeat (d) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (d) @(posedge clk);
      #1;
    end
    uart_rx = stop;
    repeat (d) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // TX line monitor: detects a start bit, samples each bit mid-period, checks against tx_q.
  initial begin : tx_monitor
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && uart_tx === 1'b0) begin
        logic [7:0] b;
        int d;
        d = tb_div;
        repeat (d + d / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = uart_tx;
          if (i < 7) repeat (d) @(negedge clk);
        end
        repeat (d) @(negedge clk);
        check("tx_stop_bit", {31'd0, uart_tx}, 32'd1);
        if (tx_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL tx_unexpected_byte: got %h, required no byte", b);
        end else begin
          check("tx_byte", {24'd0, b}, {24'd0, tx_q.pop_front()});
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd;
    logic [31:0] rd2;
    logic [9:0]  frame;
    int cyc;

    vecs[0] = '{2'd0, 32'h0000_0000, 32'h0000_0004, 1'b1, 1'b0};
    vecs[1] = '{2'd2, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{2'd3, 32'h0001_FFFF, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3] = '{2'd0, 32'hDEAD_BEEF, 32'h0000_0004, 1'b1, 1'b0};
    vecs[4] = '{2'd3, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};  // clamps to 4
    vecs[5] = '{2'd0, 32'h0000_0000, 32'h0000_0004, 1'b1, 1'b0};

    // Reset state, observed while reset is asserted.
    #1;
    check("reset_tx", {31'd0, uart_tx}, 32'd1);
    check("reset_irq", {31'd0, rx_irq}, 32'd0);
    #22;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].op, vecs[i].data, rd);
      check($sformatf("vec%0d_out", i), rd, vecs[i].exp_out);
      check($sformatf("vec%0d_tx", i), {31'd0, uart_tx}, {31'd0, vecs[i].exp_tx});
      check($sformatf("vec%0d_irq", i), {31'd0, rx_irq}, {31'd0, vecs[i].exp_irq});
    end

    // TX 0xA5 at the clamped divisor of 4: start, 8 data bits LSB first, stop, 4 cycles each.
    frame = {1'b1, 8'hA5, 1'b0};
    tx_q.push_back(8'hA5);
    do_op(OP_TX_WRITE, 32'h0000_00A5, rd);
    check("tx_write_rd", rd, 32'd0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 40; c++) begin
      check($sformatf("tx_a5_c%0d", c), {31'd0, uart_tx}, {31'd0, frame[c / 4]});
      @(posedge clk);
      #1;
    end
    check("tx_a5_line_idle", {31'd0, uart_tx}, 32'd1);
    do_op(OP_STATUS, 32'd0, rd);
    check("tx_a5_idle_status", rd, 32'h0000_0004);

    // RX 0x3C.
    send_frame(8'h3C, 1'b1, 4);
    rx_q.push_back(8'h3C);
    check("rx_3c_irq", {31'd0, rx_irq}, 32'd1);
    do_op(OP_RX_POP, 32'd0, rd);
    check("rx_3c_pop", rd, {23'd0, 1'b1, rx_q.pop_front()});
    do_op(OP_RX_POP, 32'd0, rd);
    check("rx_empty_pop", rd, 32'd0);
    check("rx_3c_irq_clear", {31'd0, rx_irq}, 32'd0);

    // Bad stop bit: no byte, frame_err set; then clear and check a short glitch is ignored.
    send_frame(8'h55, 1'b0, 4);
    do_op(OP_STATUS, 32'd0, rd);
    check("rx_frame_err", rd, 32'h0000_0014);
    check("rx_frame_err_irq", {31'd0, rx_irq}, 32'd0);
    do_op(OP_CONFIG, 32'h0001_0004, rd);
    do_op(OP_STATUS, 32'd0, rd);
    check("sticky_clear_fe", rd, 32'h0000_0004);
    uart_rx = 1'b0;
    @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    do_op(OP_STATUS, 32'd0, rd);
    check("rx_glitch", rd, 32'h0000_0004);

    // Fill the RX FIFO.
    for (int i = 0; i < 8; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1, 4);
      rx_q.push_back(8'h10 + 8'(i));
    end
    do_op(OP_STATUS, 32'd0, rd);
    check("rx_full_status", rd, 32'h0000_0805);

    // Ninth frame's stop sample lands 41 edges after the start bit is driven
    // (2 sync stages + edge register + div/2 + 8*div + div); pop on that same edge.
    fork
      send_frame(8'h18, 1'b1, 4);
      begin
        repeat (40) @(posedge clk);
        #1;
        do_op(OP_RX_POP, 32'd0, rd2);
      end
    join
    check("rx_pop_same_edge", rd2, {23'd0, 1'b1, rx_q.pop_front()});
    rx_q.push_back(8'h18);
    do_op(OP_STATUS, 32'd0, rd);
    check("rx_push_pop_no_overrun", rd, 32'h0000_0805);

    // Tenth frame with no pop overruns and is dropped.
    send_frame(8'h19, 1'b1, 4);
    do_op(OP_STATUS, 32'd0, rd);
    check("rx_overrun", rd, 32'h0000_080D);
    for (int i = 0; i < 8; i++) begin
      do_op(OP_RX_POP, 32'd0, rd);
      check($sformatf("rx_drain%0d", i), rd, {23'd0, 1'b1, rx_q.pop_front()});
    end
    do_op(OP_RX_POP, 32'd0, rd);
    check("rx_drain_empty", rd, 32'd0);
    check("rx_drain_irq", {31'd0, rx_irq}, 32'd0);
    do_op(OP_STATUS, 32'd0, rd);
    check("rx_overrun_sticky", rd, 32'h0000_000C);
    do_op(OP_CONFIG, 32'h0001_0004, rd);

    // TX overflow at a slow divisor: first byte goes to the shifter, 8 fill, ninth drops.
    tb_div = 100;
    do_op(OP_CONFIG, 32'h0000_0064, rd);
    tx_q.push_back(8'h40);
    do_op(OP_TX_WRITE, 32'h0000_0040, rd);
    @(posedge clk);
    #1;
    do_op(OP_STATUS, 32'd0, rd);
    check("tx_shifter_busy", rd, 32'h0000_0000);
    for (int i = 0; i < 8; i++) begin
      tx_q.push_back(8'h41 + 8'(i));
      do_op(OP_TX_WRITE, 32'h41 + i, rd);
    end
    do_op(OP_STATUS, 32'd0, rd);
    check("tx_full_status", rd, 32'h0008_0002);
    do_op(OP_TX_WRITE, 32'h0000_0049, rd);
    do_op(OP_STATUS, 32'd0, rd);
    check("tx_overflow", rd, 32'h0008_0022);
    do_op(OP_CONFIG, 32'h0001_0064, rd);
    do_op(OP_STATUS, 32'd0, rd);
    check("tx_overflow_clear", rd, 32'h0008_0002);

    cyc = 0;
    while (uart_data_out[2] !== 1'b1 && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("tx_drain_in_time", {31'd0, cyc < 20000}, 32'd1);
    check("tx_all_bytes_seen", tx_q.size(), 32'd0);

    // Reset in the middle of a start bit forces the line high without a clock edge.
    mon_en = 1'b0;
    do_op(OP_CONFIG, 32'h0000_0004, rd);
    do_op(OP_TX_WRITE, 32'h0000_007E, rd);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("tx_midframe_low", {31'd0, uart_tx}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("tx_async_reset_high", {31'd0, uart_tx}, 32'd1);
    #8;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(OP_STATUS, 32'd0, rd);
    check("status_after_reset", rd, 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped UART peripheral; the responder on the core's UART channel. It answers the 2-bit `UART_OP` strobe with `uart_data_out` and consumes `data_to_mem`.
- Contains one TX FIFO and one RX FIFO, an 8N1 serialiser and a mid-bit-sampling deserialiser. The baud divisor is programmable.
- Sits beside the RAM and GPIO responders. It needs no handshake beyond the single-cycle op strobe.

Parameters:
- FIFO_DEPTH, 8, entries per FIFO; power of 2, range 2..128.
- DEFAULT_DIV, 16'd434, clock cycles per bit after reset.
- MIN_DIV, 16'd4, floor applied to any programmed divisor.

Ports:
- clk, input, 1, core clock.
- rst_n, input, 1, reset, asynchronous, active-low. The block has one clock domain (clk). Reset is asynchronous and active-low (rst_n).
- uart_op, input, 2, op strobe from core; nonzero for exactly one cycle per access. Value 0 is non-editing.
- data_to_mem, input, 32, write data from core; valid while uart_op is nonzero.
- uart_data_out, output, 32, combinational read data for the current uart_op.
- uart_rx, input, 1, serial in; asynchronous to clk.
- uart_tx, output, 1, serial out; idles high.
- rx_irq, output, 1, high while the RX FIFO is non-empty.

Behaviour:
- Op timing: the core captures uart_data_out on the same clk edge that ends the op cycle. Therefore:
  - read data is purely combinational from state and uart_op;
  - all side effects commit on that edge.
- Op 0, STATUS (the core writes back the result; no side effect). uart_data_out is:
  - bit 0: rx_valid (RX FIFO non-empty)
  - bit 1: tx_full
  - bit 2: tx_idle (TX FIFO empty and shifter idle)
  - bit 3: rx_overrun, sticky
  - bit 4: frame_err, sticky
  - bit 5: tx_overflow, sticky
  - bits [15:8]: rx_count
  - bits [23:16]: tx_count
  - all other bits 0.
- Op 1, TX_WRITE (no write-back; uart_data_out = 0):
  - data_to_mem[7:0] is pushed to the TX FIFO.
  - If the TX FIFO is full, the byte is dropped and tx_overflow is set.
- Op 2, RX_POP (the core writes back the result):
  - If the RX FIFO is non-empty, uart_data_out = {23'b0, 1'b1, head}, and the head is popped at the edge.
  - If it is empty, uart_data_out = 0 and nothing changes.
- Op 3, CONFIG (no write-back; uart_data_out = 0):
  - divisor ← max(data_to_mem[15:0], MIN_DIV).
  - If data_to_mem[16] = 1, the three sticky bits are cleared.
  - The new divisor is latched by TX and RX only at their next start bit; a frame in flight completes at the old rate.
- Reset values:
  - uart_tx = 1, rx_irq = 0.
  - Both FIFOs empty, sticky bits 0, divisor = DEFAULT_DIV, TX and RX FSMs in IDLE.
  - uart_data_out with op 0 = 32'h0000_0004.
- Reset mid-frame aborts immediately; uart_tx goes high asynchronously.
- TX FSM states: IDLE → START → DATA → STOP.
  - IDLE: when the FIFO is non-empty, pop into the shifter, latch the divisor, go to START.
  - START: uart_tx = 0 for div cycles.
  - DATA: 8 bits, LSB first, div cycles each.
  - STOP: uart_tx = 1 for div cycles, then IDLE. Back-to-back frames have no extra idle cycle.
  - tx_idle = 1 only in IDLE with the FIFO empty.
- RX synchroniser: uart_rx passes through a 2-FF synchroniser, reset value 1.
- RX FSM states: IDLE → START → DATA → STOP → WAIT_HIGH.
  - IDLE: on a synchronised falling edge, latch the divisor and go to START.
  - START: wait div/2 (integer) cycles. If the line is high, it was a glitch; return to IDLE. Otherwise go to DATA.
  - DATA: sample 8 bits, each div cycles apart, LSB first.
  - STOP: sample after div cycles.
    - Sample high: push the byte. If the FIFO is full, drop it and set rx_overrun. Go to IDLE.
    - Sample low: discard the byte, set frame_err, go to WAIT_HIGH.
  - WAIT_HIGH: wait until the line is high, then IDLE.
- Simultaneous events:
  - RX push and op-2 pop on the same edge: both happen and rx_count is unchanged. A full FIFO plus pop plus push does not overrun.
  - TX-FSM pop and op-1 push on the same edge: both happen. A full FIFO plus push plus pop still drops the write and flags tx_overflow (full is evaluated before the pop).
  - Op 3 clearing sticky bits on the same edge as a new error event: the set wins.
- Counters: a down-counter of width 16 for bit timing and a 3-bit bit index. Counts saturate at FIFO_DEPTH and never wrap.

Decomposition:
- Package uart_mmio_pkg holds:
  - enum uart_op_e {OP_STATUS, OP_TX_WRITE, OP_RX_POP, OP_CONFIG};
  - status bit-position localparams;
  - TX and RX state enums.
- One sub-module, uart_fifo, is instantiated twice. It is a synchronous FIFO with push/pop/full/empty/count and registered storage, and shows head data combinationally (first-word fall-through).

Test Plan:
- Reset, then op 0 → uart_data_out = 32'h0000_0004; uart_tx = 1; rx_irq = 0.
- Op 3 with 32'h0000_0004, then op 1 with 8'hA5 → uart_tx shows start 0, then 1,0,1,0,0,1,0,1, then stop 1; each bit 4 cycles; total 40 cycles; tx_idle returns to 1.
- Drive 8'h3C on uart_rx at div 4 → rx_irq rises after the stop sample; op 2 returns 32'h0000_013C; a second op 2 returns 0; rx_irq = 0.
- Push 9 bytes via op 1 with the divisor set high (FIFO_DEPTH 8, shifter busy after the first pop) → tx_count saturates at 8; the ninth write drops; status bit 5 = 1. Op 3 with bit 16 set → status bit 5 = 0.
- RX frame with stop bit low → nothing pushed, frame_err = 1. A 1-cycle low glitch on uart_rx → no byte and no error.
- Fill RX to 8, then op 2 on the same edge as the ninth stop sample → count stays 8 and rx_overrun = 0. Repeat without a pop → rx_overrun = 1, and the FIFO contents are the first 8 bytes unchanged.
